// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV64I pipeline forwarding/hazard logic.
package riscv_pipe_pkg;

    // Register address width the stage record is built around.
    localparam int PIPE_REG_AW = 5;

    // Operand-mux select encodings; 2'b11 is never produced.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    // What the controller remembers about the instruction occupying a stage.
    typedef struct packed {
        logic                   valid;
        logic [PIPE_REG_AW-1:0] rd;
        logic                   reg_write;
        logic                   mem_read;
    } stage_info_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// Compares one source register against the two producers that will sit in
// EX/MEM and MEM/WB next cycle and picks the operand-mux select.
// The younger producer (currently in EX) wins; x0 is never forwarded.
module fwd_sel_cmp
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic [REG_AW-1:0] src,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [SEL_W-1:0]  sel
);

    logic ex_hit;
    logic mem_hit;

    // Priority select: EX producer overrides the older MEM producer.
    always_comb begin
        ex_hit  = ex_valid  & ex_reg_write  & (ex_rd  != '0) & (ex_rd  == src);
        mem_hit = mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == src);
        sel     = SEL_W'(FWD_REGFILE);
        if (ex_hit) begin
            sel = SEL_W'(FWD_MEM);
        end else if (mem_hit) begin
            sel = SEL_W'(FWD_WB);
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage RV64I pipeline.
// Tracks destination registers of in-flight instructions, registers the EX
// operand-mux selects and raises a one-cycle stall on load-use hazards.
// Optional feature: define HAZ_PERF_EN to build saturating stall/forward
// performance counters; otherwise stall_count/fwd_count are tied to zero.
module fwd_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int SEL_W      = 2,
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [SEL_W-1:0]      forward_a,
    output logic [SEL_W-1:0]      forward_b,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic [PERF_CNT_W-1:0] stall_count,
    output logic [PERF_CNT_W-1:0] fwd_count
);

    // The WB-stage record is not kept: once an instruction leaves MEM/WB its
    // result is already in the register file, so no decision ever reads it.
    stage_info_t       ex_q, ex_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_reg_write_q, mem_reg_write_d;
    logic [SEL_W-1:0]  forward_a_q, forward_a_d;
    logic [SEL_W-1:0]  forward_b_q, forward_b_d;
    logic [SEL_W-1:0]  fa_nxt, fb_nxt;
    logic              load_use;
    logic              issue;

    // Load-use detection; flush and reset both suppress the stall.
    always_comb begin
        load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
                 & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
        stall    = id_valid & load_use & ~flush & ~reset;
        issue    = id_valid & ~stall & ~flush;
    end

    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign idex_bubble = stall | flush;
    assign forward_a   = forward_a_q;
    assign forward_b   = forward_b_q;

    fwd_sel_cmp #(.REG_AW(REG_AW), .SEL_W(SEL_W)) u_sel_a (
        .src           (id_rs1),
        .ex_valid      (ex_q.valid),
        .ex_reg_write  (ex_q.reg_write),
        .ex_rd         (ex_q.rd),
        .mem_valid     (mem_valid_q),
        .mem_reg_write (mem_reg_write_q),
        .mem_rd        (mem_rd_q),
        .sel           (fa_nxt)
    );

    fwd_sel_cmp #(.REG_AW(REG_AW), .SEL_W(SEL_W)) u_sel_b (
        .src           (id_rs2),
        .ex_valid      (ex_q.valid),
        .ex_reg_write  (ex_q.reg_write),
        .ex_rd         (ex_q.rd),
        .mem_valid     (mem_valid_q),
        .mem_reg_write (mem_reg_write_q),
        .mem_rd        (mem_rd_q),
        .sel           (fb_nxt)
    );

    // Next stage records and selects; a bubble carries no destination or select.
    always_comb begin
        ex_d            = '0;
        forward_a_d     = SEL_W'(FWD_REGFILE);
        forward_b_d     = SEL_W'(FWD_REGFILE);
        mem_valid_d     = ex_q.valid;
        mem_rd_d        = ex_q.rd;
        mem_reg_write_d = ex_q.reg_write;
        if (issue) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            forward_a_d    = fa_nxt;
            forward_b_d    = fb_nxt;
        end
    end

    // Shadow pipeline registers and registered selects.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q            <= '0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            forward_a_q     <= '0;
            forward_b_q     <= '0;
        end else begin
            ex_q            <= ex_d;
            mem_valid_q     <= mem_valid_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            forward_a_q     <= forward_a_d;
            forward_b_q     <= forward_b_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [PERF_CNT_W-1:0] stall_count_q, stall_count_d;
    logic [PERF_CNT_W-1:0] fwd_count_q, fwd_count_d;

    // Saturating counters: stop at all-ones rather than wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        fwd_count_d   = fwd_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + PERF_CNT_W'(1);
        end
        if (((forward_a_q != '0) || (forward_b_q != '0)) && !(&fwd_count_q)) begin
            fwd_count_d = fwd_count_q + PERF_CNT_W'(1);
        end
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, a saturation
// sequence and randomized traffic checked against an in-order pipeline model.
module tb_fwd_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_reg_write, id_mem_read, flush;
    logic [1:0]    forward_a, forward_b;
    logic          stall, pc_write, ifid_write, idex_bubble;
    logic [CW-1:0] stall_count, fwd_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .SEL_W(2), .PERF_CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .stall_count  (stall_count),
        .fwd_count    (fwd_count)
    );

    typedef struct {
        logic       rst, v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr, fl, es;
        logic [1:0] efa, efb;
    } vec_t;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw, mr;
    } minst_t;

    vec_t   vecs[$];
    minst_t m_ex, m_mem;
    logic [1:0] m_fa = 2'b00, m_fb = 2'b00;
    int     m_sc = 0, m_fc = 0;

    task automatic addVec(input logic rst, input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic fl, input logic es,
                          input logic [1:0] efa, input logic [1:0] efb);
        vec_t t;
        t.rst = rst; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.rw = rw; t.mr = mr; t.fl = fl; t.es = es; t.efa = efa; t.efb = efb;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic fl);
        reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Does an in-flight instruction write register r (x0 never counts)?
    function automatic logic writesReg(input minst_t p, input logic [4:0] r);
        return p.v && p.rw && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    // Load in EX whose result the ID instruction needs, unless killed by flush/reset.
    function automatic logic modelStall();
        return !reset && id_valid && !flush && m_ex.v && m_ex.mr && (m_ex.rd != 5'd0)
               && ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));
    endfunction

    // Where does an operand come from: youngest in-flight writer of the register.
    function automatic logic [1:0] modelSrc(input logic [4:0] r);
        if (writesReg(m_ex, r))  return 2'b10;
        if (writesReg(m_mem, r)) return 2'b01;
        return 2'b00;
    endfunction

    // Advance the model over one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic issue;
        logic es;
        minst_t nb;
        nb.v = 1'b0; nb.rd = 5'd0; nb.rw = 1'b0; nb.mr = 1'b0;
        if (reset) begin
            m_ex = nb; m_mem = nb; m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fc = 0;
        end else begin
            es = modelStall();
            if (es && m_sc < CMAX) m_sc++;
            if ((m_fa != 2'b00 || m_fb != 2'b00) && m_fc < CMAX) m_fc++;
            issue = id_valid && !es && !flush;
            m_fa  = issue ? modelSrc(id_rs1) : 2'b00;
            m_fb  = issue ? modelSrc(id_rs2) : 2'b00;
            m_mem = m_ex;
            if (issue) begin
                m_ex.v = 1'b1; m_ex.rd = id_rd; m_ex.rw = id_reg_write; m_ex.mr = id_mem_read;
            end else begin
                m_ex = nb;
            end
        end
    endtask

    task automatic runCycle(input string tag, input logic es, input logic [1:0] efa,
                            input logic [1:0] efb);
        #3;
        checkOutput({tag, ".stall"}, 32'(stall), 32'(es));
        checkOutput({tag, ".pc_write"}, 32'(pc_write), 32'(!es));
        checkOutput({tag, ".ifid_write"}, 32'(ifid_write), 32'(!es));
        checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(es | flush));
        checkOutput({tag, ".forward_a"}, 32'(forward_a), 32'(efa));
        checkOutput({tag, ".forward_b"}, 32'(forward_b), 32'(efb));
`ifdef HAZ_PERF_EN
        checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(m_sc));
        checkOutput({tag, ".fwd_count"}, 32'(fwd_count), 32'(m_fc));
`else
        checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'd0);
        checkOutput({tag, ".fwd_count"}, 32'(fwd_count), 32'd0);
`endif
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_ex.v = 1'b0;  m_ex.rd = 5'd0;  m_ex.rw = 1'b0;  m_ex.mr = 1'b0;
        m_mem = m_ex;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        // rst v rs1 rs2 rd rw mr fl | stall fa fb (fa/fb = registered value seen this cycle)
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        // back-to-back EX/MEM forward
        addVec(0, 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 5, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00);
        // MEM/WB forward one instruction apart
        addVec(0, 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 2, 5, 7, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01);
        // x5 produced twice; youngest wins
        addVec(0, 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 3, 4, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 5, 5, 10, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10);
        // load-use: one stall then WB forward on both operands
        addVec(0, 1, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 8, 8, 9, 1, 0, 0, 1, 2'b00, 2'b00);
        addVec(0, 1, 8, 8, 9, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01);
        // x0 is never forwarded from EX/MEM or MEM/WB
        addVec(0, 1, 1, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        // load-use coinciding with flush: no stall, bubble
        addVec(0, 1, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 8, 1, 9, 1, 0, 1, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        // reset during a would-be stall
        addVec(0, 1, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00);
        addVec(1, 1, 8, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 8, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        // flush kills a pending forward select
        addVec(0, 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        addVec(0, 1, 5, 5, 6, 1, 0, 1, 0, 2'b00, 2'b00);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                          vecs[i].rw, vecs[i].mr, vecs[i].fl);
            runCycle($sformatf("vec%0d", i), vecs[i].es, vecs[i].efa, vecs[i].efb);
        end

        // 20 load-use stalls to drive the counters into saturation
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        runCycle("sat_rst", modelStall(), m_fa, m_fb);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1, 0, 8, 1, 1, 0);
            runCycle("sat_ld", modelStall(), m_fa, m_fb);
            applyStimulus(0, 1, 8, 8, 9, 1, 0, 0);
            runCycle("sat_use", modelStall(), m_fa, m_fb);
            applyStimulus(0, 1, 8, 8, 9, 1, 0, 0);
            runCycle("sat_iss", modelStall(), m_fa, m_fb);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            runCycle("sat_nop", modelStall(), m_fa, m_fb);
        end
`ifdef HAZ_PERF_EN
        checkOutput("stall_count_saturated", 32'(stall_count), 32'd15);
        checkOutput("fwd_count_saturated", 32'(fwd_count), 32'd15);
`else
        checkOutput("stall_count_absent", 32'(stall_count), 32'd0);
        checkOutput("fwd_count_absent", 32'(fwd_count), 32'd0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 9) == 0));
            runCycle($sformatf("rand%0d", i), modelStall(), m_fa, m_fb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
